// File: rtl/xbus_scheduler_if.sv
// Bus bundle between the global buffer, the scheduler and the PE array.
`timescale 1ns/1ps
interface xbus_scheduler_if #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4
);
  logic                       start;
  logic                       flush;
  logic [7:0]                 kernel_size;
  logic [$clog2(NUM_ROW):0]   cfg_rows;
  logic [$clog2(NUM_COL):0]   cfg_cols;
  logic                       in_valid;
  logic [DATA_WIDTH-1:0]      in_data;
  logic                       in_ready;
  logic                       out_valid;
  logic [DATA_WIDTH-1:0]      out_data;
  logic [$clog2(NUM_ROW):0]   out_y_tag;
  logic [$clog2(NUM_COL):0]   out_x_id;
  logic                       out_ready;
  logic                       busy;
  logic                       done;
  logic                       cfg_err;

  modport slave (
    input  start, flush, kernel_size, cfg_rows, cfg_cols, in_valid, in_data, out_ready,
    output in_ready, out_valid, out_data, out_y_tag, out_x_id, busy, done, cfg_err
  );

  modport master (
    output start, flush, kernel_size, cfg_rows, cfg_cols, in_valid, in_data, out_ready,
    input  in_ready, out_valid, out_data, out_y_tag, out_x_id, busy, done, cfg_err
  );
endinterface

// File: rtl/xbus_scheduler.sv
// Streams global-buffer words onto the PE bus tagged with (row, column) in row-major scan order.
// Optional: define XBUS_SCHED_PERF_EN to add a 32-bit stall_cnt output.
`timescale 1ns/1ps
module xbus_scheduler #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_COL    = 4,
  parameter int NUM_ROW    = 4
) (
  input  logic            clk,
  input  logic            rstn,
  xbus_scheduler_if.slave bus
`ifdef XBUS_SCHED_PERF_EN
  ,
  output logic [31:0]     stall_cnt
`endif
);
  localparam int RW = $clog2(NUM_ROW) + 1;
  localparam int CW = $clog2(NUM_COL) + 1;
  localparam int TW = 8 + RW + CW;

  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DRAIN = 2'd2, DONE = 2'd3} state_t;

  state_t                state_r, state_nxt_s;
  logic [7:0]            ks_r, word_cnt_r;
  logic [RW-1:0]         rows_r, y_cnt_r, out_y_r;
  logic [CW-1:0]         cols_r, x_cnt_r, out_x_r;
  logic [TW-1:0]         total_cnt_r, total_words_s;
  logic [DATA_WIDTH-1:0] out_data_r;
  logic                  out_valid_r, cfg_err_r;
  logic                  in_ready_s, busy_s, done_s;
  logic                  accept_s, last_s, cfg_bad_s, start_ok_s, out_free_s;

  assign cfg_bad_s = (bus.kernel_size == 8'd0) || (bus.cfg_rows == RW'(0)) || (bus.cfg_cols == CW'(0)) ||
                     (bus.cfg_rows > RW'(NUM_ROW)) || (bus.cfg_cols > CW'(NUM_COL));
  assign start_ok_s    = (state_r == IDLE) && bus.start && !bus.flush && !cfg_bad_s;
  assign out_free_s    = !out_valid_r || bus.out_ready;
  assign accept_s      = bus.in_valid && in_ready_s;
  assign total_words_s = TW'(ks_r) * TW'(rows_r) * TW'(cols_r);
  // The flat word counter marks the final word of the scan independently of the tag counters.
  assign last_s        = (total_cnt_r == total_words_s - TW'(1));

  // State register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_r <= IDLE;
    else       state_r <= state_nxt_s;
  end

  // Next-state logic; flush overrides every transition.
  always_comb begin
    state_nxt_s = state_r;
    if (bus.flush) begin
      state_nxt_s = IDLE;
    end else begin
      case (state_r)
        IDLE:    if (start_ok_s)          state_nxt_s = RUN;   else state_nxt_s = IDLE;
        RUN:     if (accept_s && last_s)  state_nxt_s = DRAIN; else state_nxt_s = RUN;
        DRAIN:   if (out_free_s)          state_nxt_s = DONE;  else state_nxt_s = DRAIN;
        DONE:    state_nxt_s = IDLE;
        default: state_nxt_s = IDLE;
      endcase
    end
  end

  // State-decoded outputs.
  always_comb begin
    in_ready_s = (state_r == RUN) && out_free_s;
    busy_s     = (state_r != IDLE);
    done_s     = (state_r == DONE);
  end

  // Configuration latch, scan counters and the output register.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ks_r        <= 8'd0;
      rows_r      <= RW'(0);
      cols_r      <= CW'(0);
      word_cnt_r  <= 8'd0;
      x_cnt_r     <= CW'(0);
      y_cnt_r     <= RW'(0);
      total_cnt_r <= TW'(0);
      out_valid_r <= 1'b0;
      out_data_r  <= DATA_WIDTH'(0);
      out_y_r     <= RW'(0);
      out_x_r     <= CW'(0);
    end else if (bus.flush) begin
      word_cnt_r  <= 8'd0;
      x_cnt_r     <= CW'(0);
      y_cnt_r     <= RW'(0);
      total_cnt_r <= TW'(0);
      out_valid_r <= 1'b0;
    end else begin
      if (start_ok_s) begin
        ks_r        <= bus.kernel_size;
        rows_r      <= bus.cfg_rows;
        cols_r      <= bus.cfg_cols;
        word_cnt_r  <= 8'd0;
        x_cnt_r     <= CW'(0);
        y_cnt_r     <= RW'(0);
        total_cnt_r <= TW'(0);
      end
      if (accept_s) begin
        out_valid_r <= 1'b1;
        out_data_r  <= bus.in_data;
        out_y_r     <= y_cnt_r;
        out_x_r     <= x_cnt_r;
        total_cnt_r <= total_cnt_r + TW'(1);
        if (word_cnt_r == ks_r - 8'd1) begin
          word_cnt_r <= 8'd0;
          if (x_cnt_r == cols_r - CW'(1)) begin
            x_cnt_r <= CW'(0);
            y_cnt_r <= (y_cnt_r == rows_r - RW'(1)) ? RW'(0) : y_cnt_r + RW'(1);
          end else begin
            x_cnt_r <= x_cnt_r + CW'(1);
          end
        end else begin
          word_cnt_r <= word_cnt_r + 8'd1;
        end
      end else if (bus.out_ready) begin
        out_valid_r <= 1'b0;
      end
    end
  end

  // One-cycle pulse for a start carrying an unusable configuration.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) cfg_err_r <= 1'b0;
    else       cfg_err_r <= (state_r == IDLE) && bus.start && !bus.flush && cfg_bad_s;
  end

`ifdef XBUS_SCHED_PERF_EN
  // Saturating count of cycles the bus held a word it could not deliver.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                                                       stall_cnt <= 32'd0;
    else if (start_ok_s)                                             stall_cnt <= 32'd0;
    else if (out_valid_r && !bus.out_ready && stall_cnt != 32'hFFFF_FFFF) stall_cnt <= stall_cnt + 32'd1;
  end
`endif

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_data  = out_data_r;
  assign bus.out_y_tag = out_y_r;
  assign bus.out_x_id  = out_x_r;
  assign bus.busy      = busy_s;
  assign bus.done      = done_s;
  assign bus.cfg_err   = cfg_err_r;
endmodule

// File: tb/tb_xbus_scheduler.sv
// Self-checking bench for xbus_scheduler: configuration table plus hand-written corner sequences.
`timescale 1ns/1ps
module tb_xbus_scheduler;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int NR = 4;
  localparam int RW = $clog2(NR) + 1;
  localparam int CW = $clog2(NC) + 1;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  xbus_scheduler_if #(.DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR)) bus();
`ifdef XBUS_SCHED_PERF_EN
  logic [31:0] stall_cnt;
`endif

  xbus_scheduler #(.DATA_WIDTH(DW), .NUM_COL(NC), .NUM_ROW(NR)) dut (
    .clk(clk),
    .rstn(rstn),
    .bus(bus)
`ifdef XBUS_SCHED_PERF_EN
    ,
    .stall_cnt(stall_cnt)
`endif
  );

  typedef struct { logic [DW-1:0] data; logic [RW-1:0] y; logic [CW-1:0] x; } exp_t;
  typedef struct { int ks; int rows; int cols; bit exp_err; int exp_words; bit rnd; } vec_t;

  exp_t exp_q[$];
  vec_t vecs[8];
  int n_cmp = 0, n_bad = 0, cyc = 0, last_xfer = -10;
  int n_sent, words_out, done_seen, err_seen, tb_ks = 1, tb_cols = 1;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // One clock: drive data, sample mid-cycle, update the scoreboard, return at the next negedge.
  task automatic step();
    exp_t e;
    bus.in_data = DW'(32'hA000 + n_sent);
    #2;
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++; n_bad++;
        $display("FAIL unexpected_word: got data %0h, expected no word", bus.out_data);
      end else begin
        e = exp_q.pop_front();
        chk("out_data", bus.out_data, e.data);
        chk("out_y_tag", bus.out_y_tag, e.y);
        chk("out_x_id", bus.out_x_id, e.x);
      end
      words_out++;
      last_xfer = cyc;
    end
    if (bus.out_valid && !bus.out_ready) chk("in_ready_stalled", bus.in_ready, 0);
    if (bus.in_valid && bus.in_ready) begin
      e.data = DW'(32'hA000 + n_sent);
      e.y    = RW'(n_sent / (tb_ks * tb_cols));
      e.x    = CW'((n_sent / tb_ks) % tb_cols);
      exp_q.push_back(e);
      n_sent++;
    end
    if (bus.done) begin
      done_seen++;
      chk("done_latency", cyc - last_xfer, 1);
    end
    if (bus.cfg_err) err_seen++;
    cyc++;
    @(negedge clk);
  endtask

  task automatic start_scan(input int ks, input int rows, input int cols);
    tb_ks = (ks == 0) ? 1 : ks;
    tb_cols = (cols == 0) ? 1 : cols;
    n_sent = 0; words_out = 0; done_seen = 0; err_seen = 0;
    exp_q.delete();
    bus.kernel_size = 8'(ks);
    bus.cfg_rows = RW'(rows);
    bus.cfg_cols = CW'(cols);
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    bus.start = 1'b1;
    step();
    bus.start = 1'b0;
  endtask

  task automatic run_scan(input int ks, input int rows, input int cols, input bit exp_err,
                          input int exp_words, input bit rnd, input int restart_at);
    int budget;
    int tail;
    start_scan(ks, rows, cols);
    chk("busy_after_start", bus.busy, exp_err ? 0 : 1);
    budget = exp_words * 4 + 20;
    tail = 0;
    for (int i = 0; i < budget && tail < 3; i++) begin
      if (done_seen > 0) tail++;
      bus.out_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      if (i == restart_at) begin
        bus.start = 1'b1;
        bus.kernel_size = 8'd1;
        bus.cfg_rows = RW'(1);
        bus.cfg_cols = CW'(1);
      end
      step();
      bus.start = 1'b0;
    end
    chk("words_out", words_out, exp_words);
    chk("words_in", n_sent, exp_words);
    chk("done_count", done_seen, exp_err ? 0 : 1);
    chk("cfg_err_count", err_seen, exp_err ? 1 : 0);
    chk("sb_leftover", exp_q.size(), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    vecs[0] = '{3, 2, 2, 1'b0, 12, 1'b0};
    vecs[1] = '{1, 1, 1, 1'b0, 1,  1'b0};
    vecs[2] = '{2, 4, 4, 1'b0, 32, 1'b1};
    vecs[3] = '{5, 1, 3, 1'b0, 15, 1'b1};
    vecs[4] = '{3, 2, 5, 1'b1, 0,  1'b0};
    vecs[5] = '{0, 2, 2, 1'b1, 0,  1'b0};
    vecs[6] = '{2, 0, 1, 1'b1, 0,  1'b0};
    vecs[7] = '{1, 5, 1, 1'b1, 0,  1'b0};

    bus.start = 1'b0; bus.flush = 1'b0; bus.kernel_size = 8'd0;
    bus.cfg_rows = RW'(0); bus.cfg_cols = CW'(0);
    bus.in_valid = 1'b0; bus.in_data = DW'(0); bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_in_ready", bus.in_ready, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_cfg_err", bus.cfg_err, 0);
    chk("rst_out_data", bus.out_data, 0);
    rstn = 1'b1;
    @(negedge clk);

    foreach (vecs[i]) run_scan(vecs[i].ks, vecs[i].rows, vecs[i].cols, vecs[i].exp_err, vecs[i].exp_words, vecs[i].rnd, -1);

    // Backpressure: five stalled cycles after the fourth delivered word.
    start_scan(3, 2, 2);
    for (int g = 0; g < 50 && words_out < 4; g++) step();
    bus.out_ready = 1'b0;
    for (int s = 0; s < 5; s++) begin
      chk("bp_out_valid", bus.out_valid, 1);
      chk("bp_hold_data", bus.out_data, exp_q[0].data);
      chk("bp_hold_y", bus.out_y_tag, exp_q[0].y);
      chk("bp_hold_x", bus.out_x_id, exp_q[0].x);
      step();
    end
    chk("bp_no_progress", words_out, 4);
    bus.out_ready = 1'b1;
    for (int g = 0; g < 60 && done_seen == 0; g++) step();
    step();
    chk("bp_words", words_out, 12);
    chk("bp_done", done_seen, 1);
    chk("bp_sb_leftover", exp_q.size(), 0);
`ifdef XBUS_SCHED_PERF_EN
    chk("bp_stall_cnt", stall_cnt, 5);
`endif

    // Flush while the seventh word sits on the bus, then flush racing a start.
    start_scan(3, 2, 2);
    for (int g = 0; g < 50 && !(bus.out_valid && words_out == 6); g++) step();
    bus.flush = 1'b1;
    step();
    bus.flush = 1'b0;
    chk("fl_out_valid", bus.out_valid, 0);
    chk("fl_busy", bus.busy, 0);
    chk("fl_words", words_out, 7);
    exp_q.delete();
    bus.flush = 1'b1; bus.start = 1'b1;
    step();
    bus.flush = 1'b0; bus.start = 1'b0;
    chk("fl_beats_start", bus.busy, 0);
    repeat (5) step();
    chk("fl_no_done", done_seen, 0);
    chk("fl_no_cfg_err", err_seen, 0);
    chk("fl_no_words", words_out, 7);
    run_scan(3, 2, 2, 1'b0, 12, 1'b0, -1);

    // Start while busy must not disturb the running 2x2x2 scan.
    run_scan(2, 2, 2, 1'b0, 8, 1'b0, 3);

    // Reset while the single word of a 1x1x1 scan waits in DRAIN.
    start_scan(1, 1, 1);
    step();
    chk("drain_busy", bus.busy, 1);
    chk("drain_in_ready", bus.in_ready, 0);
    chk("drain_out_valid", bus.out_valid, 1);
    rstn = 1'b0;
    #1;
    chk("mid_rst_out_valid", bus.out_valid, 0);
    chk("mid_rst_out_data", bus.out_data, 0);
    chk("mid_rst_y", bus.out_y_tag, 0);
    chk("mid_rst_x", bus.out_x_id, 0);
    chk("mid_rst_busy", bus.busy, 0);
    chk("mid_rst_in_ready", bus.in_ready, 0);
    @(negedge clk);
    rstn = 1'b1;
    exp_q.delete();
    repeat (6) step();
    chk("post_rst_no_done", done_seen, 0);
    chk("post_rst_no_words", words_out, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
